mem_arbiter: RTL

- Shares the single-ported, multi-cycle main memory between the I-cache miss path and the D-cache miss and write-through store path.
- Sits between both cache controllers and the memory model.
- For a miss, it sequences an 8-word block fill: it pipelines the 8 read requests, counts the data returns, and drives word writes and the tag write into the requesting cache.
- It issues D-side single-word stores as one-cycle writes.

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_fill_counter.sv | 41 ++++
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the main-memory arbiter between the I-cache
// and D-cache miss/store paths.
package mem_arbiter_pkg;

  localparam int          BLOCK_WORDS = 8;
  localparam int          MEM_LAT     = 4;
  localparam logic [15:0] BLOCK_MASK  = 16'hFFF0;
  localparam logic [2:0]  LAST_WORD   = 3'(BLOCK_WORDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_WRITE = 3'd4
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_fill_counter.sv
// 3-bit word counter for block fills: clears, increments, and holds at the
// last word index so a stray extra pulse can never wrap it.
module mem_fill_counter
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [2:0] cnt,
  output logic       tc
);

  logic [2:0] cnt_d;
  logic [2:0] cnt_q;

  // Next count: clear wins over increment; saturate at the last word.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 3'd0;
    end else if (inc && (cnt_q != LAST_WORD)) begin
      cnt_d = cnt_q + 3'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == LAST_WORD);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported main memory between I-miss fills, D-miss fills
// and D-side write-through stores; sequences 8-word pipelined block fills.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic              mem_data_valid,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_out,
  output logic [DATA_W-1:0] fill_data,
  output logic [2:0]        fill_word,
  output logic              i_fill_we,
  output logic              d_fill_we,
  output logic              i_fill_done,
  output logic              d_fill_done,
  output logic              d_wr_ack,
  output logic              busy
);

  state_e            state_d, state_q;
  owner_e            owner_d, owner_q;
  logic [ADDR_W-1:0] base_d, base_q;

  logic [2:0] issue_cnt_s;
  logic       issue_tc_s;
  logic [2:0] rcv_cnt_s;
  logic       rcv_tc_s;
  logic       fill_acc_s;

  // Returns only count while a fill is in flight; stale data elsewhere is dropped.
  assign fill_acc_s = ((state_q == ST_ISSUE) || (state_q == ST_DRAIN)) && mem_data_valid;

  mem_fill_counter u_issue_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q == ST_IDLE),
    .inc   (state_q == ST_ISSUE),
    .cnt   (issue_cnt_s),
    .tc    (issue_tc_s)
  );

  mem_fill_counter u_rcv_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   ((state_q == ST_IDLE) || (state_q == ST_DONE)),
    .inc   (fill_acc_s),
    .cnt   (rcv_cnt_s),
    .tc    (rcv_tc_s)
  );

  // State, owner and block base registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_I;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      base_q  <= base_d;
    end
  end

  // Next state; requests are only looked at in IDLE, store beats D-miss beats I-miss.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    base_d  = base_q;
    case (state_q)
      ST_IDLE: begin
        if (d_wr_req) begin
          state_d = ST_WRITE;
        end else if (d_miss) begin
          state_d = ST_ISSUE;
          owner_d = OWN_D;
          base_d  = d_miss_addr & ADDR_W'(BLOCK_MASK);
        end else if (i_miss) begin
          state_d = ST_ISSUE;
          owner_d = OWN_I;
          base_d  = i_miss_addr & ADDR_W'(BLOCK_MASK);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (issue_tc_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (mem_data_valid && rcv_tc_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; fill writes follow mem_data_valid in the same cycle.
  always_comb begin
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_data_out = '0;
    fill_data    = '0;
    fill_word    = 3'd0;
    i_fill_we    = 1'b0;
    d_fill_we    = 1'b0;
    i_fill_done  = 1'b0;
    d_fill_done  = 1'b0;
    d_wr_ack     = 1'b0;
    busy         = (state_q != ST_IDLE);
    case (state_q)
      ST_ISSUE: begin
        mem_en   = 1'b1;
        mem_addr = base_q + ADDR_W'({issue_cnt_s, 1'b0});
      end
      ST_WRITE: begin
        mem_en       = 1'b1;
        mem_wr       = 1'b1;
        mem_addr     = d_wr_addr;
        mem_data_out = d_wr_data;
        d_wr_ack     = 1'b1;
      end
      ST_DONE: begin
        i_fill_done = (owner_q == OWN_I);
        d_fill_done = (owner_q == OWN_D);
      end
      default: begin
        mem_en = 1'b0;
      end
    endcase
    if (fill_acc_s) begin
      fill_data = mem_data_in;
      fill_word = rcv_cnt_s;
      i_fill_we = (owner_q == OWN_I);
      d_fill_we = (owner_q == OWN_D);
    end else begin
      fill_data = '0;
      fill_word = 3'd0;
    end
  end

endmodule
